// File: rtl/tmem_bank_loader.sv
// Host-side texture memory loader: scatters a linear word stream across the
// interleaved banks (bank = X mod BANKS, physical address = X >> BANK_BITS).
module tmem_bank_loader #(
    parameter int WIDTH      = 32,
    parameter int BANKS      = 4,
    parameter int BANK_BITS  = 2,
    parameter int BANK_DEPTH = 50000
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             START_I,
    input  logic [WIDTH-1:0] BASE_I,
    input  logic [WIDTH-1:0] COUNT_I,
    input  logic             ABORT_I,
    input  logic [WIDTH-1:0] DAT_I,
    input  logic             DAT_VLD_I,
    output logic             DAT_RDY_O,
    output logic [WIDTH-1:0] TMDAT_O,
    output logic [WIDTH-1:0] TMADR_O,
    output logic             TMWE_O,
    output logic [BANKS-1:0] TMSEL_O,
    output logic             BUSY_O,
    output logic             DONE_O,
    output logic             ERR_O
);

    localparam logic [WIDTH:0] LIMIT = (WIDTH+1)'(BANKS * BANK_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dat;
    logic [WIDTH-1:0] r_adr;
    logic [BANKS-1:0] r_sel;
    logic             r_we;
    logic             r_done;
    logic             r_err;
    logic [WIDTH:0]   w_end;
    logic             w_start_ok;
    logic             w_start_rej;
    logic             w_accept;
    logic             w_abort;

    always_ff @(posedge CLK_I) begin
        if (RST_I) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_start_rej = 1'b0;
        w_accept    = 1'b0;
        w_abort     = 1'b0;
        // One extra bit so BASE+COUNT overflow cannot slip past the range check
        w_end       = {1'b0, BASE_I} + {1'b0, COUNT_I};
        DAT_RDY_O   = (r_state == ST_LOAD);
        BUSY_O      = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (START_I) begin
                    if (COUNT_I == '0 || w_end > LIMIT) begin
                        w_start_rej = 1'b1;
                    end else begin
                        w_start_ok  = 1'b1;
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (ABORT_I) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (DAT_VLD_I) begin
                    w_accept = 1'b1;
                    if (r_rem == WIDTH'(1)) w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            r_addr <= '0;
            r_rem  <= '0;
            r_dat  <= '0;
            r_adr  <= '0;
            r_sel  <= '0;
            r_we   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_we   <= w_accept;
            r_done <= (r_state == ST_FLUSH);
            r_err  <= w_start_rej | w_abort;
            if (w_start_ok) begin
                r_addr <= BASE_I;
                r_rem  <= COUNT_I;
            end else if (w_accept) begin
                r_addr <= r_addr + WIDTH'(1);
                r_rem  <= r_rem - WIDTH'(1);
                r_dat  <= DAT_I;
                r_sel  <= BANKS'(r_addr[BANK_BITS-1:0]);
                r_adr  <= r_addr >> BANK_BITS;
            end
        end
    end

    assign TMDAT_O = r_dat;
    assign TMADR_O = r_adr;
    assign TMSEL_O = r_sel;
    assign TMWE_O  = r_we;
    assign DONE_O  = r_done;
    assign ERR_O   = r_err;

endmodule

// File: tb/tb_tmem_bank_loader.sv
// Self-checking bench for tmem_bank_loader: directed and randomized loads
// checked against an address-arithmetic model of the expected bank writes.
module tb_tmem_bank_loader;

    logic        CLK_I = 1'b0;
    logic        RST_I, START_I, ABORT_I, DAT_VLD_I;
    logic [31:0] BASE_I, COUNT_I, DAT_I;
    logic        DAT_RDY_O, TMWE_O, BUSY_O, DONE_O, ERR_O;
    logic [31:0] TMDAT_O, TMADR_O;
    logic [3:0]  TMSEL_O;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_dat = '0;
    logic [31:0] last_adr = '0;
    logic [31:0] last_sel = '0;

    tmem_bank_loader #(.WIDTH(32), .BANKS(4), .BANK_BITS(2), .BANK_DEPTH(50000)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .START_I(START_I), .BASE_I(BASE_I),
        .COUNT_I(COUNT_I), .ABORT_I(ABORT_I), .DAT_I(DAT_I), .DAT_VLD_I(DAT_VLD_I),
        .DAT_RDY_O(DAT_RDY_O), .TMDAT_O(TMDAT_O), .TMADR_O(TMADR_O), .TMWE_O(TMWE_O),
        .TMSEL_O(TMSEL_O), .BUSY_O(BUSY_O), .DONE_O(DONE_O), .ERR_O(ERR_O)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"},  DAT_RDY_O, 0);
        chk({tag, "_dat"},  TMDAT_O, 0);
        chk({tag, "_adr"},  TMADR_O, 0);
        chk({tag, "_sel"},  TMSEL_O, 0);
        chk({tag, "_we"},   TMWE_O, 0);
        chk({tag, "_busy"}, BUSY_O, 0);
        chk({tag, "_done"}, DONE_O, 0);
        chk({tag, "_err"},  ERR_O, 0);
    endtask

    // mode: 0 continuous valid, 1 valid toggling 1/0, 2 random valid.
    // abort_at / rst_at: beat index (accepted-beat count) at which to abort / reset, -1 for none.
    task automatic do_load(input logic [31:0] base, input logic [31:0] count, input int mode,
                           input int abort_at, input int rst_at, input bit busy_start,
                           input bit seqdat);
        longint      endv = longint'(base) + longint'(count);
        bit          ok   = (count != 0) && (endv <= 200000);
        int          k    = 0;
        int          cyc  = 0;
        bit          v, ab, rs;
        logic [31:0] d, x;

        START_I = 1'b1; BASE_I = base; COUNT_I = count;
        ABORT_I = 1'($urandom % 2);
        step();
        START_I = 1'b0; ABORT_I = 1'b0; BASE_I = $urandom; COUNT_I = $urandom;
        chk("start_err",  ERR_O, !ok);
        chk("start_busy", BUSY_O, ok);
        chk("start_we",   TMWE_O, 0);
        chk("start_done", DONE_O, 0);
        if (!ok) begin
            step();
            chk("rej_err_clear", ERR_O, 0);
            chk("rej_busy", BUSY_O, 0);
            chk("rej_we", TMWE_O, 0);
            return;
        end

        while (k < int'(count) && cyc < 2000) begin
            cyc++;
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 1);
                default: v = 1'($urandom % 2);
            endcase
            ab = v && (k == abort_at);
            rs = (k == rst_at);
            d  = seqdat ? 32'hA0 + 32'(k) : $urandom;
            DAT_I = d; DAT_VLD_I = v; ABORT_I = ab; RST_I = rs;
            if (busy_start && k == 2) begin
                START_I = 1'b1; BASE_I = 100; COUNT_I = 8;
            end
            chk("load_rdy", DAT_RDY_O, 1);
            step();
            START_I = 1'b0; ABORT_I = 1'b0; DAT_VLD_I = 1'b0;
            if (rs) begin
                RST_I = 1'b0;
                chk_all_zero("rst_mid");
                for (int i = 0; i < 3; i++) begin
                    step();
                    chk("rst_after_we", TMWE_O, 0);
                    chk("rst_after_busy", BUSY_O, 0);
                end
                return;
            end
            if (ab) begin
                chk("abort_we", TMWE_O, 0);
                chk("abort_rdy", DAT_RDY_O, 0);
                chk("abort_busy", BUSY_O, 0);
                chk("abort_err", ERR_O, 1);
                chk("abort_done", DONE_O, 0);
                step();
                chk("abort_err_clear", ERR_O, 0);
                chk("abort_done2", DONE_O, 0);
                chk("abort_we2", TMWE_O, 0);
                return;
            end
            if (v) begin
                x = base + 32'(k);
                last_sel = x % 4; last_adr = x / 4; last_dat = d;
                k++;
                chk("wr_we", TMWE_O, 1);
            end else begin
                chk("stall_we", TMWE_O, 0);
            end
            chk("wr_sel", TMSEL_O, last_sel);
            chk("wr_adr", TMADR_O, last_adr);
            chk("wr_dat", TMDAT_O, last_dat);
            chk("load_err", ERR_O, 0);
            chk("load_done", DONE_O, 0);
            chk("load_busy", BUSY_O, 1);
        end
        chk("load_beats", k, count);
        chk("flush_rdy", DAT_RDY_O, 0);
        step();
        chk("done_pulse", DONE_O, 1);
        chk("done_busy", BUSY_O, 0);
        chk("done_we", TMWE_O, 0);
        chk("done_err", ERR_O, 0);
        step();
        chk("done_clear", DONE_O, 0);
    endtask

    initial begin
        RST_I = 1'b1; START_I = 1'b0; ABORT_I = 1'b0; DAT_VLD_I = 1'b0;
        BASE_I = '0; COUNT_I = '0; DAT_I = '0;
        step(); step();
        RST_I = 1'b0;
        chk_all_zero("reset");

        do_load(0, 8, 0, -1, -1, 0, 1);
        do_load(6, 5, 1, -1, -1, 0, 0);
        do_load(199996, 4, 0, -1, -1, 0, 0);
        chk("range_last_adr", last_adr, 49999);
        chk("range_last_sel", last_sel, 3);
        do_load(199997, 4, 0, -1, -1, 0, 0);
        do_load(5, 0, 0, -1, -1, 0, 0);
        do_load(32'hFFFF_FFFF, 2, 0, -1, -1, 0, 0);
        do_load(0, 10, 0, 4, -1, 0, 0);
        do_load(0, 8, 0, -1, -1, 1, 0);
        do_load(0, 8, 0, -1, 3, 0, 0);
        do_load(0, 8, 0, -1, -1, 0, 0);

        ABORT_I = 1'b1;
        step();
        ABORT_I = 1'b0;
        chk("idle_abort_err", ERR_O, 0);
        chk("idle_abort_busy", BUSY_O, 0);

        for (int i = 0; i < 8; i++) begin
            if (i % 3 == 2)
                do_load($urandom_range(199980, 200010), $urandom_range(0, 12), 2, -1, -1, 0, 0);
            else
                do_load($urandom_range(0, 199980), $urandom_range(1, 12), 2, -1, -1, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tmem_bank_loader.md
Name: tmem_bank_loader

Overview:
- Host-side writer that fills the interleaved texture memory banks from a linear word stream.
- For each linear (virtual) word address X it drives the bank write port with bank = X mod BANKS and physical address = X >> BANK_BITS.
- This is the exact inverse of the mapping the core-side crossbar uses when reading.
- Sits between the host DMA/stream source and the GPU top-level TMDAT/TMADR/TMWE/TMSEL inputs.

Parameters:
- WIDTH, 32, data and address width (matches WB_WIDTH).
- BANKS, 4, number of texture memory banks; must be a power of two.
- BANK_BITS, 2, log2(BANKS).
- BANK_DEPTH, 50000, words per bank.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  reset; synchronous, active-high.
- START_I  in  1  one-cycle pulse; requests a load of COUNT_I words starting at linear address BASE_I.
- BASE_I  in  WIDTH  first linear word address; sampled on an accepted START_I.
- COUNT_I  in  WIDTH  number of words; sampled on an accepted START_I.
- ABORT_I  in  1  terminates an active load.
- DAT_I  in  WIDTH  stream data.
- DAT_VLD_I  in  1  stream data valid.
- DAT_RDY_O  out  1  loader ready for a stream word.
- TMDAT_O  out  WIDTH  bank write data.
- TMADR_O  out  WIDTH  physical address within the bank.
- TMWE_O  out  1  bank write enable.
- TMSEL_O  out  BANKS  bank index (binary, zero-extended to BANKS bits).
- BUSY_O  out  1  load in progress.
- DONE_O  out  1  one-cycle pulse: load complete.
- ERR_O  out  1  one-cycle pulse: start rejected, or load aborted.

Behaviour:
- Reset: every output is 0, FSM enters IDLE, internal address and remaining-count registers are 0. Reset mid-load drops the load immediately; no further TMWE_O pulses are issued.
- FSM states: IDLE, LOAD, FLUSH.
- IDLE:
  - DAT_RDY_O = 0, BUSY_O = 0.
  - On START_I, compute end = BASE_I + COUNT_I at WIDTH+1 bits.
  - Reject the start (ERR_O pulses the next cycle, stay in IDLE) if COUNT_I == 0 or end > BANKS*BANK_DEPTH.
  - Otherwise latch addr = BASE_I and rem = COUNT_I, go to LOAD; BUSY_O = 1 from the next cycle.
- LOAD:
  - DAT_RDY_O = 1.
  - A beat is accepted when DAT_VLD_I & DAT_RDY_O.
  - On each accepted beat: addr += 1, rem -= 1. The write port registers are loaded from the pre-increment addr:
    - TMDAT_O <= DAT_I
    - TMSEL_O <= addr[BANK_BITS-1:0]
    - TMADR_O <= addr >> BANK_BITS
    - TMWE_O <= 1
  - Cycles with no accepted beat: TMWE_O <= 0; TMDAT_O, TMADR_O and TMSEL_O hold their values.
  - Latency: exactly one cycle from accepted beat to TMWE_O high. Throughput: one word per cycle.
  - When the last beat (rem == 1) is accepted, DAT_RDY_O drops in the next cycle and the FSM goes to FLUSH.
- FLUSH: lasts one cycle, during which the final TMWE_O is high. DONE_O pulses in the cycle after FLUSH, together with BUSY_O going 0 and the return to IDLE.
- Bank rotation:
  - Consecutive beats visit banks BASE mod BANKS, then +1, and so on, wrapping to 0 after bank BANKS-1.
  - TMADR_O increments by one each time the bank index wraps from BANKS-1 to 0.
  - Addresses never wrap past BANKS*BANK_DEPTH-1; the range check at start guarantees this.
- START_I while BUSY_O = 1 is ignored: no error, and the latched values are unchanged.
- ABORT_I:
  - In LOAD, an abort takes priority over a beat in the same cycle. That beat is not accepted and not written.
  - Next cycle: DAT_RDY_O = 0, TMWE_O = 0, BUSY_O = 0, ERR_O pulses, FSM goes to IDLE. Words already written remain in the banks.
  - ABORT_I in IDLE has no effect.
- Simultaneous START_I and ABORT_I in IDLE: the start is evaluated normally.
- DONE_O and ERR_O are never high in the same cycle.

Test Plan:
- Basic rotation: BASE=0, COUNT=8, continuous valid, data 0xA0..0xA7.
  - Required: 8 TMWE_O pulses with (TMSEL,TMADR) = (0,0)(1,0)(2,0)(3,0)(0,1)(1,1)(2,1)(3,1) and matching data.
  - First TMWE_O one cycle after the first accepted beat; DONE_O pulses once; BUSY_O falls with DONE_O.
- Unaligned base with stalls: BASE=6, COUNT=5, DAT_VLD_I toggling 1/0.
  - Required: writes at (2,1)(3,1)(0,2)(1,2)(2,2); TMWE_O low in every cycle following a non-accepted cycle.
- Range check:
  - BASE=199996, COUNT=4: accepted; last write at bank 3, TMADR 49999.
  - BASE=199997, COUNT=4: rejected with ERR_O pulse, no TMWE_O.
  - COUNT=0: rejected with ERR_O pulse.
- Abort: BASE=0, COUNT=10, ABORT_I asserted in the same cycle as beat 4 (0-based).
  - Required: exactly 4 writes (addresses 0..3), then ERR_O pulse, BUSY_O=0, no DONE_O.
- Start while busy: during a COUNT=8 load, pulse START_I with BASE=100.
  - Required: the load completes unchanged at addresses 0..7.
- Reset mid-load: assert RST_I after 3 writes of a COUNT=8 load.
  - Required: next cycle all outputs are 0 and no further TMWE_O.
  - A new START_I (BASE=0, COUNT=8) then works normally.
